// File: rtl/reg_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback (req 0) vs long-latency unit (req 1),
// with a busy scoreboard for req-1 writes. Define WB_STARVE_GUARD_EN to add the starvation guard.
module reg_wb_arbiter #(
   parameter int MAX_WAIT = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        wb0_valid_i,
   input  logic [4:0]  wb0_rd_i,
   input  logic [31:0] wb0_data_i,
   input  logic        wb1_valid_i,
   output logic        wb1_ready_o,
   input  logic [4:0]  wb1_rd_i,
   input  logic [31:0] wb1_data_i,
   input  logic        issue_i,
   input  logic [4:0]  issue_rd_i,
   output logic [31:0] busy_o,
   output logic        stall_o,
   output logic        ovr_err_o,
   output logic [4:0]  rsW_o,
   output logic [31:0] dataW_o,
   output logic        RegWEn_o
);

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } wb_req_t;

   generate
      if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_max_wait
         $error("reg_wb_arbiter: MAX_WAIT must be in 1..15");
      end
   endgenerate

   wb_req_t     req0, req1, win;
   logic        grant0, grant1;
   logic        stall_q;
   logic [31:0] busy_q, busy_n;

   assign req0 = '{rd: wb0_rd_i, data: wb0_data_i};
   assign req1 = '{rd: wb1_rd_i, data: wb1_data_i};

   // During a forced slot the pipeline request is dropped outright.
   always_comb begin
      grant0 = wb0_valid_i & ~stall_q;
      grant1 = wb1_valid_i & (stall_q | ~wb0_valid_i) & ~rst_i;
      win    = grant0 ? req0 : req1;
   end

   assign wb1_ready_o = grant1;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rsW_o    <= '0;
         dataW_o  <= '0;
         RegWEn_o <= 1'b0;
      end else if (grant0 | grant1) begin
         rsW_o    <= win.rd;
         dataW_o  <= win.data;
         RegWEn_o <= |win.rd;
      end else begin
         RegWEn_o <= 1'b0;
      end
   end

   // Set after clear so a same-cycle issue to the retiring register stays busy.
   always_comb begin
      busy_n = busy_q;
      if (grant1)
         busy_n[wb1_rd_i] = 1'b0;
      if (issue_i && issue_rd_i != 5'd0)
         busy_n[issue_rd_i] = 1'b1;
      busy_n[0] = 1'b0;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) busy_q <= '0;
      else       busy_q <= busy_n;
   end

   assign busy_o = busy_q;

`ifdef WB_STARVE_GUARD_EN
   typedef enum logic {NORMAL, FORCE} state_t;

   state_t     state_q, state_n;
   logic [3:0] wait_q, wait_n;
   logic       ovr_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= NORMAL;
         wait_q  <= '0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_n;
         wait_q  <= wait_n;
         ovr_q   <= ovr_q | (stall_q & wb0_valid_i);
      end
   end

   always_comb begin
      state_n = state_q;
      wait_n  = wait_q;
      case (state_q)
         NORMAL: begin
            if (wb1_valid_i && !grant1) begin
               if (wait_q == 4'(MAX_WAIT - 1)) begin
                  state_n = FORCE;
                  wait_n  = '0;
               end else begin
                  wait_n = wait_q + 4'd1;
               end
            end else begin
               wait_n = '0;
            end
         end
         FORCE: begin
            state_n = NORMAL;
            wait_n  = '0;
         end
         default: begin
            state_n = NORMAL;
            wait_n  = '0;
         end
      endcase
   end

   assign stall_q   = (state_q == FORCE);
   assign ovr_err_o = ovr_q;
`else
   assign stall_q   = 1'b0;
   assign ovr_err_o = 1'b0;
`endif

   assign stall_o = stall_q;

endmodule

// File: doc/reg_wb_arbiter.md
# reg_wb_arbiter

Arbitrates the single register-file write port between the in-order pipeline writeback (requester 0) and the long-latency unit (requester 1: divider or load miss return). It keeps a 32-entry scoreboard of destination registers with writes still outstanding from requester 1, so hazard logic can stall dependent instructions. It sits between writeback and the register file's `dataW_i`/`rsW_i`/`RegWEn_i` inputs and adds a registered stage to the write path.

## Interface
- `MAX_WAIT`, 4: consecutive cycles requester 1 may be blocked before the starvation guard forces a slot (range 1..15).
- `clk_i` input 1: clock; all state updates on posedge.
- `rst_i` input 1: asynchronous, active-high reset.
- `wb0_valid_i` input 1: pipeline writeback request; has no backpressure.
- `wb0_rd_i` input 5: pipeline destination register.
- `wb0_data_i` input 32: pipeline write data.
- `wb1_valid_i` input 1: long-latency unit write request.
- `wb1_ready_o` output 1: requester 1 accepted this cycle (combinational).
- `wb1_rd_i` input 5: long-latency destination register.
- `wb1_data_i` input 32: long-latency write data.
- `issue_i` input 1: long-latency op dispatched this cycle.
- `issue_rd_i` input 5: destination of dispatched op.
- `busy_o` output 32: scoreboard; bit n = register n has a pending requester-1 write.
- `stall_o` output 1: registered; pipeline must not present `wb0_valid_i` this cycle.
- `ovr_err_o` output 1: sticky; `wb0_valid_i` seen while `stall_o`=1.
- `rsW_o` output 5, `dataW_o` output 32, `RegWEn_o` output 1: registered write-port drive to the register file.

## Operation
- Grant is combinational per cycle. Normal: `wb0_valid_i`=1 grants requester 0; otherwise `wb1_valid_i`=1 grants requester 1 (`wb1_ready_o`=1).
- When `stall_o`=1: requester 1 is granted if valid; `wb0_valid_i` is ignored (its write is dropped) and `ovr_err_o` is set. It stays set until reset.
- Granted request is registered: next cycle `rsW_o`/`dataW_o` take its rd/data. `RegWEn_o`=1 only if rd≠0, so writes to x0 are accepted but never performed. With no grant, `RegWEn_o`=0 and `rsW_o`/`dataW_o` hold their previous values.
- Requester 1 must hold rd/data stable while `wb1_valid_i`=1 and `wb1_ready_o`=0.
- Scoreboard: `issue_i` with `issue_rd_i`≠0 sets `busy[issue_rd_i]`. An accepted requester-1 write clears `busy[wb1_rd_i]`. If both target the same register in one cycle, set wins. `busy_o[0]` is constant 0. The scoreboard updates at the same edge as the grant register.
- Starvation guard FSM:
  - NORMAL: a cycle with `wb1_valid_i`=1 and no grant increments `wait_cnt`. A grant, or `wb1_valid_i`=0, clears `wait_cnt`. When `wait_cnt` reaches `MAX_WAIT`, go to FORCE and assert `stall_o` on the next cycle.
  - FORCE: `stall_o`=1 for exactly one cycle. Requester 1 is granted if valid; if it dropped valid, the slot is unused. Return to NORMAL with `wait_cnt`=0.

## Timing
- Reset values: `rsW_o`=0, `dataW_o`=0, `RegWEn_o`=0, `stall_o`=0, `ovr_err_o`=0, `busy_o`=0, `wait_cnt`=0, FSM=NORMAL. `wb1_ready_o` is 0 while `rst_i`=1.
- Latency from grant (cycle N) to write-port drive is 1 cycle (N+1). The register file commits at the end of N+1, and `busy` clears at the end of N.
- Worst-case requester-1 wait is `MAX_WAIT` blocked cycles plus one forced cycle.
- Reset asserted mid-operation clears all state immediately. Any in-flight registered write is lost (`RegWEn_o`=0).

## Configuration
- `WB_STARVE_GUARD_EN` defined: starvation guard FSM, `wait_cnt`, `stall_o` and `ovr_err_o` logic are present as described.
- Not defined: strict fixed priority to requester 0. `stall_o` and `ovr_err_o` are tied to 0, `MAX_WAIT` is unused, and requester 1 can starve indefinitely.

## Test plan
- Reset, then `wb1_valid_i`=1 with rd=5, data=0xDEADBEEF, and `wb0_valid_i`=0 → `wb1_ready_o`=1 the same cycle. Next cycle `RegWEn_o`=1, `rsW_o`=5, `dataW_o`=0xDEADBEEF.
- Same cycle `wb0` (rd=3, 0x11) and `wb1` (rd=7, 0x22) → `wb0` written in cycle N+1. `wb1_ready_o`=0 until `wb0` idles, then rd=7 is written one cycle after acceptance.
- Guard enabled, `MAX_WAIT`=4, `wb0_valid_i` held 1 and `wb1` valid → after 4 blocked cycles `stall_o`=1 for one cycle and `wb1` is granted; `ovr_err_o` becomes 1 because `wb0` was still asserted.
- `issue_i` with rd=9 → `busy_o[9]`=1. Later `wb1` write to rd=9 accepted → `busy_o[9]`=0 the next cycle. Issue and accept of rd=9 in the same cycle → `busy_o[9]` stays 1.
- Write to x0 via each requester → handshake completes and `RegWEn_o` stays 0. `issue_rd_i`=0 → `busy_o` stays 0.
- Assert `rst_i` asynchronously while `stall_o`=1 and a write is registered → all outputs go to reset values immediately, with no clock edge needed.
